mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipelined core: consumes the EX/MEM pipeline register outputs, drives a request/ready data-memory port, stalls the front of the pipe while a load/store is outstanding, resolves the branch decision, and registers the MEM/WB pipeline register. It sits between the EX/MEM register and the write-back mux, and is the reader/consumer end of the EX/MEM interface.

## Interface
- `XLEN`, 32: data and address width.
- `RA_W`, 5: register-index width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_mem_MemtoReg`, `ex_mem_MemRead`, `ex_mem_MemWrite`, `ex_mem_Branch`, `ex_mem_RegWrite` in 1 each: control bits from EX/MEM.
- `pc_out` in XLEN: branch target from EX/MEM.
- `out_zero` in 1: ALU zero flag.
- `alu_resultaddress` in XLEN: ALU result / memory address.
- `writedata` in XLEN: store data.
- `ex_rd` in RA_W: destination register.
- `dmem_req` out 1: memory request valid.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out XLEN; `dmem_wdata` out XLEN.
- `dmem_ready` in 1: memory accepts/completes request this cycle.
- `dmem_rdata` in XLEN: load data, valid when `dmem_req && dmem_ready && !dmem_we`.
- `mem_stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- `pc_src` out 1, `branch_target` out XLEN: branch redirect.
- `mem_wb_RegWrite`, `mem_wb_MemtoReg` out 1; `mem_wb_readdata`, `mem_wb_alu_result` out XLEN; `mem_wb_rd` out RA_W.
- `misalign_err` out 1: sticky misaligned-access flag.
- `load_count`, `store_count`, `stall_count` out 32: saturating performance counters.

## Operation
- `mem_op = (MemRead | MemWrite) & (alu_resultaddress[1:0] == 0)`; MemWrite has priority if both are set.
- Misaligned (address[1:0] != 0) with MemRead or MemWrite: no request issued, `misalign_err` set (sticky until reset), instruction retires as a bubble (`mem_wb_RegWrite` = 0).
- FSM states IDLE, WAIT.
  - IDLE: `dmem_req = mem_op`. If `mem_op && !dmem_ready`, go to WAIT. Otherwise stay.
  - WAIT: `dmem_req = 1`. Stay until `dmem_ready`, then go to IDLE.
- `dmem_addr`, `dmem_wdata`, `dmem_we` are driven from the EX/MEM inputs. They are stable throughout WAIT because upstream is frozen.
- `mem_stall = dmem_req & !dmem_ready` (combinational).
- MEM/WB update on each posedge:
  - Stall cycle: bubble (`RegWrite`/`MemtoReg` = 0, data fields hold).
  - Otherwise: copy control, `rd`, and ALU result; on a completing load, capture `dmem_rdata` into `mem_wb_readdata`.
- `pc_src = ex_mem_Branch & out_zero`; `branch_target = pc_out`. Both are combinational, and zero while `mem_stall`.
- Counters:
  - `load_count` / `store_count` increment on each completing load/store handshake.
  - `stall_count` increments on each stall cycle.
  - All counters saturate at 2^32-1.
- `dmem_ready` while `dmem_req` = 0 is ignored.

## Timing
- Zero-wait memory (ready with req): no stall; MEM/WB valid next edge; 1-cycle stage latency.
- N wait cycles: `mem_stall` high for exactly N cycles; MEM/WB gets N bubbles then the result.
- Reset values:
  - All outputs 0, state IDLE.
  - `dmem_req` drops immediately on `rst_n` low, including mid-WAIT; no completion is recorded.
  - Counters and `misalign_err` are cleared.
- Reset release: first edge behaves as IDLE.
- Upstream contract: EX/MEM holds its contents while `mem_stall` = 1. This block does not check it.

## Structure
- Shared core package holds `XLEN`, `RA_W`, the FSM state enum (IDLE, WAIT), and the saturating-increment function.
- One natural sub-module: `sat_counter` (32-bit, enable, async active-low clear), instantiated three times.

## Test plan
- Zero-wait load, addr 0x10, `dmem_rdata`=0xDEADBEEF, ready same cycle -> `mem_stall` never high; next edge `mem_wb_readdata`=0xDEADBEEF, `mem_wb_RegWrite`=1, `load_count`=1.
- Store with ready after 3 cycles, addr 0x20, data 0x1234 -> `dmem_req`/`dmem_we` high 4 cycles, addr/data stable, `mem_stall` high 3 cycles, `stall_count`=3, 3 MEM/WB bubbles, `store_count`=1.
- Load at addr 0x22 -> no `dmem_req`, `misalign_err`=1 and stays set, `mem_wb_RegWrite`=0.
- Branch=1, zero=1, `pc_out`=0x40 -> `pc_src`=1, `branch_target`=0x40 same cycle; with zero=0 -> `pc_src`=0.
- `rst_n` low in WAIT cycle 2 -> `dmem_req` 0 immediately, state IDLE, counters 0, MEM/WB cleared.
- Counter preset near max (force 0xFFFFFFFF) plus a further stall -> `stall_count` stays 0xFFFFFFFF.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: widths, FSM state encoding
// and the saturating increment used by the performance counters.
package mem_stage_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/ready data-memory port between the MEM stage (master) and the
// data memory (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_r;

    // Count enabled events, holding at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd0;
        end else if (en) begin
            count_r <= sat_inc(count_r);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-memory requests from EX/MEM, stalls the front of the
// pipe while an access is outstanding, resolves branches and registers MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_MemtoReg,
    input  logic              ex_mem_MemRead,
    input  logic              ex_mem_MemWrite,
    input  logic              ex_mem_Branch,
    input  logic              ex_mem_RegWrite,
    input  logic [XLEN-1:0]   pc_out,
    input  logic              out_zero,
    input  logic [XLEN-1:0]   alu_resultaddress,
    input  logic [XLEN-1:0]   writedata,
    input  logic [RA_W-1:0]   ex_rd,
    mem_stage_if.master       dmem,
    output logic              mem_stall,
    output logic              pc_src,
    output logic [XLEN-1:0]   branch_target,
    output logic              mem_wb_RegWrite,
    output logic              mem_wb_MemtoReg,
    output logic [XLEN-1:0]   mem_wb_readdata,
    output logic [XLEN-1:0]   mem_wb_alu_result,
    output logic [RA_W-1:0]   mem_wb_rd,
    output logic              misalign_err,
    output logic [31:0]       load_count,
    output logic [31:0]       store_count,
    output logic [31:0]       stall_count
);

    state_t          state_r;
    state_t          state_next_s;
    logic            req_s;
    logic            is_mem_s;
    logic            aligned_s;
    logic            mem_op_s;
    logic            misaligned_s;
    logic            complete_s;
    logic            load_done_s;
    logic            store_done_s;
    logic            stall_s;
    logic            misalign_r;
    logic            wb_regwrite_r;
    logic            wb_memtoreg_r;
    logic [XLEN-1:0] wb_readdata_r;
    logic [XLEN-1:0] wb_alu_r;
    logic [RA_W-1:0] wb_rd_r;

    assign is_mem_s     = ex_mem_MemRead | ex_mem_MemWrite;
    assign aligned_s    = (alu_resultaddress[1:0] == 2'b00);
    assign mem_op_s     = is_mem_s & aligned_s;
    assign misaligned_s = is_mem_s & ~aligned_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and raw request.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        case (state_r)
            IDLE: begin
                req_s = mem_op_s;
                if (mem_op_s && !dmem.dmem_ready) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                req_s = 1'b1;
                if (dmem.dmem_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
                req_s        = 1'b0;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is asserted so an
    // in-flight request is withdrawn at once.
    assign dmem.dmem_req   = req_s & rst_n;
    assign dmem.dmem_we    = ex_mem_MemWrite & rst_n;
    assign dmem.dmem_addr  = rst_n ? alu_resultaddress : {XLEN{1'b0}};
    assign dmem.dmem_wdata = rst_n ? writedata : {XLEN{1'b0}};

    assign stall_s      = dmem.dmem_req & ~dmem.dmem_ready;
    assign complete_s   = dmem.dmem_req & dmem.dmem_ready;
    assign load_done_s  = complete_s & ~ex_mem_MemWrite;
    assign store_done_s = complete_s & ex_mem_MemWrite;

    assign mem_stall     = stall_s;
    assign pc_src        = ex_mem_Branch & out_zero & ~stall_s & rst_n;
    assign branch_target = (stall_s || !rst_n) ? {XLEN{1'b0}} : pc_out;

    // MEM/WB pipeline register; stalls and misaligned accesses become bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_regwrite_r <= 1'b0;
            wb_memtoreg_r <= 1'b0;
            wb_readdata_r <= {XLEN{1'b0}};
            wb_alu_r      <= {XLEN{1'b0}};
            wb_rd_r       <= {RA_W{1'b0}};
        end else if (stall_s) begin
            wb_regwrite_r <= 1'b0;
            wb_memtoreg_r <= 1'b0;
        end else begin
            wb_regwrite_r <= ex_mem_RegWrite & ~misaligned_s;
            wb_memtoreg_r <= ex_mem_MemtoReg & ~misaligned_s;
            wb_alu_r      <= alu_resultaddress;
            wb_rd_r       <= ex_rd;
            if (load_done_s) begin
                wb_readdata_r <= dmem.dmem_rdata;
            end else begin
                wb_readdata_r <= wb_readdata_r;
            end
        end
    end

    // Sticky misaligned-access flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_r | misaligned_s;
        end
    end

    assign mem_wb_RegWrite   = wb_regwrite_r;
    assign mem_wb_MemtoReg   = wb_memtoreg_r;
    assign mem_wb_readdata   = wb_readdata_r;
    assign mem_wb_alu_result = wb_alu_r;
    assign mem_wb_rd         = wb_rd_r;
    assign misalign_err      = misalign_r;

    sat_counter u_load_cnt  (.clk(clk), .rst_n(rst_n), .en(load_done_s),  .count(load_count));
    sat_counter u_store_cnt (.clk(clk), .rst_n(rst_n), .en(store_done_s), .count(store_count));
    sat_counter u_stall_cnt (.clk(clk), .rst_n(rst_n), .en(stall_s),      .count(stall_count));

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-cycle vectors followed by
// hand-written wait-state, saturation and reset sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mtr, mrd, mwr, br, rw, zero;
    logic [31:0] pc, addr, wdata;
    logic [4:0]  rd;
    logic        mem_stall, pc_src, wb_rw, wb_mtr, mis;
    logic [31:0] tgt, wb_rdata, wb_alu, ld_cnt, st_cnt, sl_cnt;
    logic [4:0]  wb_rd;
    int          total = 0;
    int          bad = 0;

    mem_stage_if mif ();

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_MemtoReg(mtr), .ex_mem_MemRead(mrd), .ex_mem_MemWrite(mwr),
        .ex_mem_Branch(br), .ex_mem_RegWrite(rw),
        .pc_out(pc), .out_zero(zero), .alu_resultaddress(addr),
        .writedata(wdata), .ex_rd(rd), .dmem(mif.master),
        .mem_stall(mem_stall), .pc_src(pc_src), .branch_target(tgt),
        .mem_wb_RegWrite(wb_rw), .mem_wb_MemtoReg(wb_mtr),
        .mem_wb_readdata(wb_rdata), .mem_wb_alu_result(wb_alu),
        .mem_wb_rd(wb_rd), .misalign_err(mis),
        .load_count(ld_cnt), .store_count(st_cnt), .stall_count(sl_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en, wr_en, mtr, rw, br, z;
        logic [31:0] pc, addr, wd;
        logic [4:0]  rdi;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req, e_we, e_stall, e_pcsrc;
        logic [31:0] e_tgt;
        logic        e_rw, e_mtr;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
        logic [31:0] e_rdata;
        logic        e_mis;
        logic [31:0] e_ld, e_st;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nop();
        mtr = 1'b0; mrd = 1'b0; mwr = 1'b0; br = 1'b0; rw = 1'b0; zero = 1'b0;
        pc = 32'd0; addr = 32'd0; wdata = 32'd0; rd = 5'd0;
        mif.dmem_ready = 1'b0; mif.dmem_rdata = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //         rd wr mt rw br z  pc     addr          wd        rdi  rdy rdata
        //         req we st psrc tgt    rw mt alu          rd   rdata         mis ld st
        vt[0] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0, 32'h10, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF,
                  1'b1,1'b0,1'b0,1'b0, 32'h0, 1'b1,1'b1, 32'h10, 5'd5, 32'hDEADBEEF, 1'b0, 32'd1, 32'd0};
        vt[1] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h24, 32'h55, 5'd0, 1'b1, 32'h11111111,
                  1'b1,1'b1,1'b0,1'b0, 32'h0, 1'b0,1'b0, 32'h24, 5'd0, 32'hDEADBEEF, 1'b0, 32'd1, 32'd1};
        vt[2] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0, 32'h12345678, 32'h0, 5'd7, 1'b1, 32'h22222222,
                  1'b0,1'b0,1'b0,1'b0, 32'h0, 1'b1,1'b0, 32'h12345678, 5'd7, 32'hDEADBEEF, 1'b0, 32'd1, 32'd1};
        vt[3] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h40, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0,
                  1'b0,1'b0,1'b0,1'b1, 32'h40, 1'b0,1'b0, 32'h0, 5'd0, 32'hDEADBEEF, 1'b0, 32'd1, 32'd1};
        vt[4] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'h40, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0,
                  1'b0,1'b0,1'b0,1'b0, 32'h40, 1'b0,1'b0, 32'h0, 5'd0, 32'hDEADBEEF, 1'b0, 32'd1, 32'd1};
        vt[5] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h30, 32'hA5A5, 5'd0, 1'b1, 32'h33333333,
                  1'b1,1'b1,1'b0,1'b0, 32'h0, 1'b0,1'b0, 32'h30, 5'd0, 32'hDEADBEEF, 1'b0, 32'd1, 32'd2};
        vt[6] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0, 32'h22, 32'h0, 5'd9, 1'b1, 32'h44444444,
                  1'b0,1'b0,1'b0,1'b0, 32'h0, 1'b0,1'b0, 32'h22, 5'd9, 32'hDEADBEEF, 1'b1, 32'd1, 32'd2};
        vt[7] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0, 32'h8, 32'h0, 5'd3, 1'b0, 32'h0,
                  1'b0,1'b0,1'b0,1'b0, 32'h0, 1'b1,1'b0, 32'h8, 5'd3, 32'hDEADBEEF, 1'b1, 32'd1, 32'd2};

        // Reset state, with a load presented so the request gating is exercised.
        nop();
        rst_n = 1'b0;
        mrd = 1'b1; addr = 32'h10;
        #1;
        chk("rst_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("rst_wb_rw", {31'd0, wb_rw}, 32'd0);
        chk("rst_cnt", ld_cnt | st_cnt | sl_cnt, 32'd0);
        chk("rst_mis", {31'd0, mis}, 32'd0);
        @(negedge clk);
        nop();
        rst_n = 1'b1;

        // Single-cycle vectors with zero-wait memory.
        for (int i = 0; i < 8; i++) begin
            mrd = vt[i].rd_en; mwr = vt[i].wr_en; mtr = vt[i].mtr; rw = vt[i].rw;
            br = vt[i].br; zero = vt[i].z; pc = vt[i].pc; addr = vt[i].addr;
            wdata = vt[i].wd; rd = vt[i].rdi;
            mif.dmem_ready = vt[i].rdy; mif.dmem_rdata = vt[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, mif.dmem_req}, {31'd0, vt[i].e_req});
            chk($sformatf("v%0d_we", i), {31'd0, mif.dmem_we}, {31'd0, vt[i].e_we});
            chk($sformatf("v%0d_addr", i), mif.dmem_addr, vt[i].addr);
            chk($sformatf("v%0d_stall", i), {31'd0, mem_stall}, {31'd0, vt[i].e_stall});
            chk($sformatf("v%0d_pcsrc", i), {31'd0, pc_src}, {31'd0, vt[i].e_pcsrc});
            chk($sformatf("v%0d_tgt", i), tgt, vt[i].e_tgt);
            step();
            chk($sformatf("v%0d_wb_rw", i), {31'd0, wb_rw}, {31'd0, vt[i].e_rw});
            chk($sformatf("v%0d_wb_mtr", i), {31'd0, wb_mtr}, {31'd0, vt[i].e_mtr});
            chk($sformatf("v%0d_wb_alu", i), wb_alu, vt[i].e_alu);
            chk($sformatf("v%0d_wb_rd", i), {27'd0, wb_rd}, {27'd0, vt[i].e_rd});
            chk($sformatf("v%0d_wb_rdata", i), wb_rdata, vt[i].e_rdata);
            chk($sformatf("v%0d_mis", i), {31'd0, mis}, {31'd0, vt[i].e_mis});
            chk($sformatf("v%0d_ld", i), ld_cnt, vt[i].e_ld);
            chk($sformatf("v%0d_st", i), st_cnt, vt[i].e_st);
        end
        chk("no_stall_yet", sl_cnt, 32'd0);

        // Store with three wait cycles; MEM/WB data holds during the bubbles.
        nop();
        mwr = 1'b1; addr = 32'h20; wdata = 32'h1234; rd = 5'd6;
        for (int c = 0; c < 4; c++) begin
            mif.dmem_ready = (c == 3) ? 1'b1 : 1'b0;
            #1;
            chk($sformatf("st_c%0d_req", c), {30'd0, mif.dmem_req, mif.dmem_we}, 32'd3);
            chk($sformatf("st_c%0d_bus", c), mif.dmem_addr ^ mif.dmem_wdata, 32'h1214);
            chk($sformatf("st_c%0d_stall", c), {31'd0, mem_stall}, (c < 3) ? 32'd1 : 32'd0);
            chk($sformatf("st_c%0d_psrc", c), {31'd0, pc_src}, 32'd0);
            step();
            if (c < 3) begin
                chk($sformatf("st_c%0d_bubble_alu", c), wb_alu, 32'h8);
                chk($sformatf("st_c%0d_bubble_rd", c), {27'd0, wb_rd}, 32'd3);
            end
        end
        nop();
        chk("st_wb_alu", wb_alu, 32'h20);
        chk("st_wb_rd", {27'd0, wb_rd}, 32'd6);
        chk("st_stall_cnt", sl_cnt, 32'd3);
        chk("st_store_cnt", st_cnt, 32'd3);
        chk("st_mis_sticky", {31'd0, mis}, 32'd1);

        // Stall counter preset to maximum stays saturated on a further stall.
        force dut.u_stall_cnt.count_r = 32'hFFFF_FFFF;
        step();
        release dut.u_stall_cnt.count_r;
        mrd = 1'b1; addr = 32'h50;
        #1;
        chk("sat_stall", {31'd0, mem_stall}, 32'd1);
        step();
        chk("sat_cnt", sl_cnt, 32'hFFFF_FFFF);
        mif.dmem_ready = 1'b1;
        step();
        nop();

        // Reset asserted in the second WAIT cycle of a load.
        mrd = 1'b1; rw = 1'b1; addr = 32'h40; rd = 5'd2;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rw_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("rw_stall", {31'd0, mem_stall}, 32'd0);
        chk("rw_state", {31'd0, dut.state_r}, {31'd0, IDLE});
        chk("rw_cnt", ld_cnt | st_cnt | sl_cnt, 32'd0);
        chk("rw_wb", wb_alu | wb_rdata | {27'd0, wb_rd} | {31'd0, wb_rw}, 32'd0);
        chk("rw_mis", {31'd0, mis}, 32'd0);
        step();
        nop();
        rst_n = 1'b1;

        // First access after reset completes as from IDLE.
        mrd = 1'b1; mtr = 1'b1; rw = 1'b1; addr = 32'h44; rd = 5'd4;
        mif.dmem_ready = 1'b1; mif.dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("pr_stall", {31'd0, mem_stall}, 32'd0);
        step();
        nop();
        chk("pr_rdata", wb_rdata, 32'hCAFEF00D);
        chk("pr_rw", {31'd0, wb_rw}, 32'd1);
        chk("pr_ld", ld_cnt, 32'd1);
        chk("pr_stall_cnt", sl_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
